// File: rtl/uart_axi_bridge_if.sv
// rtl/uart_axi_bridge_if.sv - AXI4-lite bus between the byte bridge and the UART Lite slave
//
// Ports (signals): AR  araddr[3:0] arvalid arready
//                  R   rdata[31:0] rresp[1:0] rvalid rready
//                  AW  awaddr[3:0] awvalid awready
//                  W   wdata[31:0] wstrb[3:0] wvalid wready
//                  B   bresp[1:0] bvalid bready
// master = bridge side, slave = UART side.
interface uart_axi_bridge_if;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/uart_axi_bridge.sv
// rtl/uart_axi_bridge.sv - byte-stream front end polling an AXI4-lite UART Lite
//
// Ports: clk, rstn (async active-low)
//        tx_data[7:0], tx_valid, tx_ready   core -> UART byte slot
//        rx_data[7:0], rx_valid, rx_ready   UART -> core byte slot
//        err                                sticky AXI error flag
//        uart_axi                           AXI4-lite master port (uart_axi_bridge_if.master)
module uart_axi_bridge #(
    parameter int         POLL_GAP  = 4,
    parameter logic [3:0] ADDR_RX   = 4'h0,
    parameter logic [3:0] ADDR_TX   = 4'h4,
    parameter logic [3:0] ADDR_STAT = 4'h8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              err,
    uart_axi_bridge_if.master uart_axi
);
    localparam int CW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [2:0] {IDLE, ST_AR, ST_R, RX_AR, RX_R, TX_AW, TX_B} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          prio;
    logic          tx_full;
    logic [7:0]    tx_buf;

    logic cand_tx;
    logic cand_rx;
    logic pick_tx;
    logic aw_clear;
    logic w_clear;

    // Decision terms evaluated against the STAT word on the R beat.
    always_comb begin
        cand_tx  = tx_full && !uart_axi.rdata[3];
        cand_rx  = !rx_valid && uart_axi.rdata[0];
        pick_tx  = cand_tx && (!cand_rx || !prio);
        // A channel counts as done if it already handshook or does so now.
        aw_clear = !uart_axi.awvalid || uart_axi.awready;
        w_clear  = !uart_axi.wvalid || uart_axi.wready;
    end

    assign tx_ready = !tx_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            cnt              <= '0;
            prio             <= 1'b0;
            tx_full          <= 1'b0;
            tx_buf           <= 8'h00;
            rx_valid         <= 1'b0;
            rx_data          <= 8'h00;
            err              <= 1'b0;
            uart_axi.araddr  <= 4'h0;
            uart_axi.arvalid <= 1'b0;
            uart_axi.rready  <= 1'b0;
            uart_axi.awaddr  <= 4'h0;
            uart_axi.awvalid <= 1'b0;
            uart_axi.wdata   <= 32'h0;
            uart_axi.wstrb   <= 4'h0;
            uart_axi.wvalid  <= 1'b0;
            uart_axi.bready  <= 1'b0;
        end else begin
            // Core-side slot handshakes run independently of the bus FSM.
            if (tx_valid && !tx_full) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data;
            end
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (cnt == '0) begin
                        // Poll only when there is work a STAT read could unlock.
                        if (tx_full || !rx_valid) begin
                            state            <= ST_AR;
                            uart_axi.araddr  <= ADDR_STAT;
                            uart_axi.arvalid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ST_AR, RX_AR: begin
                    if (uart_axi.arready) begin
                        uart_axi.arvalid <= 1'b0;
                        uart_axi.rready  <= 1'b1;
                        state            <= (state == ST_AR) ? ST_R : RX_R;
                    end
                end

                ST_R: begin
                    if (uart_axi.rvalid) begin
                        uart_axi.rready <= 1'b0;
                        if (uart_axi.rresp != 2'b00) err <= 1'b1;
                        if (pick_tx) begin
                            state            <= TX_AW;
                            uart_axi.awaddr  <= ADDR_TX;
                            uart_axi.awvalid <= 1'b1;
                            uart_axi.wdata   <= {24'h0, tx_buf};
                            uart_axi.wstrb   <= 4'b0001;
                            uart_axi.wvalid  <= 1'b1;
                        end else if (cand_rx) begin
                            state            <= RX_AR;
                            uart_axi.araddr  <= ADDR_RX;
                            uart_axi.arvalid <= 1'b1;
                        end else begin
                            state <= IDLE;
                            cnt   <= CW'(POLL_GAP);
                        end
                    end
                end

                RX_R: begin
                    if (uart_axi.rvalid) begin
                        uart_axi.rready <= 1'b0;
                        if (uart_axi.rresp != 2'b00) err <= 1'b1;
                        // The byte is delivered even on an error response.
                        rx_data  <= uart_axi.rdata[7:0];
                        rx_valid <= 1'b1;
                        prio     <= ~prio;
                        state    <= IDLE;
                        cnt      <= '0;
                    end
                end

                TX_AW: begin
                    if (uart_axi.awready) uart_axi.awvalid <= 1'b0;
                    if (uart_axi.wready)  uart_axi.wvalid  <= 1'b0;
                    if (aw_clear && w_clear) begin
                        state           <= TX_B;
                        uart_axi.bready <= 1'b1;
                    end
                end

                TX_B: begin
                    if (uart_axi.bvalid) begin
                        uart_axi.bready <= 1'b0;
                        if (uart_axi.bresp != 2'b00) err <= 1'b1;
                        tx_full <= 1'b0;
                        prio    <= ~prio;
                        state   <= IDLE;
                        cnt     <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_axi_bridge.sv
// tb/tb_uart_axi_bridge.sv - self-checking bench for uart_axi_bridge with a behavioural UART slave
module tb_uart_axi_bridge;
    localparam int POLL_GAP = 4;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       err;

    always #5 clk = ~clk;

    uart_axi_bridge_if bus ();

    uart_axi_bridge #(.POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .rstn(rstn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err(err), .uart_axi(bus)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- behavioural UART slave ----------------
    typedef struct {
        int          kind;   // 0 = STAT read, 1 = RX read, 2 = TX write
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ev_t;

    ev_t        log_q[$];
    logic [7:0] stat_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] stat_default = 8'h04;
    bit         stat_dynamic = 0;
    int         tx_full_pct = 0;
    int         ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    int          cyc = 0;
    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit          r_pend, b_pend, aw_done, w_done;
    logic [31:0] r_data;
    logic [3:0]  aw_addr_q, w_strb_q;
    logic [31:0] w_data_q;

    assign bus.arready = (ar_cnt >= ar_wait);
    assign bus.awready = (aw_cnt >= aw_wait);
    assign bus.wready  = (w_cnt >= w_wait);
    assign bus.rvalid  = r_pend && (r_cnt >= r_wait);
    assign bus.rdata   = r_data;
    assign bus.rresp   = rresp_cfg;
    assign bus.bvalid  = b_pend && (b_cnt >= b_wait);
    assign bus.bresp   = bresp_cfg;

    function automatic ev_t make_ev(input int k, input int c, input logic [3:0] a,
                                    input logic [31:0] d, input logic [3:0] s);
        ev_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.data = d; e.strb = s;
        return e;
    endfunction

    function automatic logic [31:0] slave_read(input logic [3:0] a);
        logic [7:0] s;
        if (a == 4'h8) begin
            if (stat_q.size() > 0) s = stat_q.pop_front();
            else if (stat_dynamic) s = {4'b0, ($urandom_range(99) < tx_full_pct), 2'b0, (rx_q.size() > 0)};
            else s = stat_default;
            return {24'h0, s};
        end
        if (a == 4'h0 && rx_q.size() > 0) return {24'h0, rx_q.pop_front()};
        return 32'h0;
    endfunction

    function automatic int count_kind(input int k);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].kind == k) n++;
        return n;
    endfunction

    wire aw_hs = bus.awvalid && bus.awready;
    wire w_hs  = bus.wvalid && bus.wready;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 0; b_pend <= 0; aw_done <= 0; w_done <= 0;
            r_data <= 32'h0;
        end else begin
            cyc <= cyc + 1;
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            if (bus.arvalid && bus.arready) begin
                r_data <= slave_read(bus.araddr);
                r_pend <= 1; r_cnt <= 0;
                log_q.push_back(make_ev((bus.araddr == 4'h8) ? 0 : 1, cyc, bus.araddr, 32'h0, 4'h0));
            end else if (r_pend) begin
                if (bus.rvalid && bus.rready) r_pend <= 0;
                else r_cnt <= r_cnt + 1;
            end
            if (aw_hs) aw_addr_q <= bus.awaddr;
            if (w_hs) begin w_data_q <= bus.wdata; w_strb_q <= bus.wstrb; end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                b_pend <= 1; b_cnt <= 0; aw_done <= 0; w_done <= 0;
                log_q.push_back(make_ev(2, cyc, aw_hs ? bus.awaddr : aw_addr_q,
                                        w_hs ? bus.wdata : w_data_q, w_hs ? bus.wstrb : w_strb_q));
            end else begin
                if (aw_hs) aw_done <= 1;
                if (w_hs) w_done <= 1;
                if (b_pend) begin
                    if (bus.bvalid && bus.bready) b_pend <= 0;
                    else b_cnt <= b_cnt + 1;
                end
            end
        end
    end

    // Protocol monitor: one outstanding transaction, AR/AW exclusive, RX slot held stable.
    int         viol = 0;
    logic       prev_rxv = 0, prev_rxr = 0;
    logic [7:0] prev_rxd = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_rxv <= 0;
        end else begin
            if ((bus.arvalid && bus.awvalid) || (bus.arvalid && (r_pend || b_pend)) ||
                (bus.awvalid && (r_pend || b_pend)) ||
                (prev_rxv && !prev_rxr && (!rx_valid || rx_data != prev_rxd)))
                viol <= viol + 1;
            prev_rxv <= rx_valid; prev_rxr <= rx_ready; prev_rxd <= rx_data;
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic apply_reset();
        tx_valid = 0; rx_ready = 0; tx_data = 8'h00;
        rstn = 0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        rresp_cfg = 2'b00; bresp_cfg = 2'b00;
        stat_default = 8'h04; stat_dynamic = 0; tx_full_pct = 0;
        stat_q.delete(); rx_q.delete();
        repeat (3) @(posedge clk);
        #1;
        log_q.delete();
        rstn = 1;
    endtask

    task automatic send_now(input logic [7:0] b);
        tx_data = b; tx_valid = 1;
        @(posedge clk); #1;
        tx_valid = 0;
    endtask

    task automatic wait_count(input int kind, input int n, input int budget, output bit ok);
        int k = 0;
        ok = 0;
        while (k < budget && !ok) begin
            if (count_kind(kind) >= n) ok = 1;
            else begin @(posedge clk); #1; k++; end
        end
    endtask

    task automatic wait_rxv(input int budget, output bit ok);
        int k = 0;
        ok = 0;
        while (k < budget && !ok) begin
            if (rx_valid) ok = 1;
            else begin @(posedge clk); #1; k++; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        rstn = 0;
        #1;
        checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
            failures++; $display("FAIL reset_valids: got %b expected 00000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
        checks++; if ({bus.araddr, bus.awaddr, bus.wstrb} !== 12'h0 || bus.wdata !== 32'h0) begin
            failures++; $display("FAIL reset_addr_data: got %h/%h/%h/%h expected zeros", bus.araddr, bus.awaddr, bus.wstrb, bus.wdata); end
        checks++; if ({tx_ready, rx_valid, err} !== 3'b100) begin
            failures++; $display("FAIL reset_slots: got tx_ready,rx_valid,err=%b expected 100", {tx_ready, rx_valid, err}); end
        checks++; if (rx_data !== 8'h00) begin
            failures++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        apply_reset();
    endtask

    task automatic test_tx_latency();
        bit [4:0] trv; logic ar0; logic [1:0] aw2; logic b3; bit ok;
        apply_reset();
        send_now(8'h5A);                 // accepted on edge 0
        trv[0] = tx_ready; ar0 = bus.arvalid;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            trv[k] = tx_ready;
            if (k == 2) aw2 = {bus.awvalid, bus.wvalid};
            if (k == 3) b3 = bus.bready;
        end
        checks++; if (trv !== 5'b10000) begin failures++; $display("FAIL lat_tx_ready: got %b expected 10000", trv); end
        checks++; if (ar0 !== 1'b1) begin failures++; $display("FAIL lat_ar_cycle1: got %b expected 1", ar0); end
        checks++; if (aw2 !== 2'b11) begin failures++; $display("FAIL lat_aw_w_cycle3: got %b expected 11", aw2); end
        checks++; if (b3 !== 1'b1) begin failures++; $display("FAIL lat_b_cycle4: got %b expected 1", b3); end
        wait_count(2, 1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lat_write_seen: got none expected 1 write"); end
        else begin
            checks++; if (log_q[$].kind != 2 || log_q[$].addr !== 4'h4 || log_q[$].data !== 32'h5A || log_q[$].strb !== 4'b0001) begin
                failures++; $display("FAIL lat_write_fields: got kind %0d addr %h data %h strb %b expected 2/4/0000005a/0001",
                                     log_q[$].kind, log_q[$].addr, log_q[$].data, log_q[$].strb); end
        end
        repeat (20) @(posedge clk); #1;
        checks++; if (count_kind(2) != 1) begin failures++; $display("FAIL lat_single_write: got %0d expected 1", count_kind(2)); end
    endtask

    task automatic test_poll_gap();
        logic [7:0] b; bit ok; int sc[$]; int nstat;
        apply_reset();
        stat_q.push_back(8'h08); stat_q.push_back(8'h08); stat_q.push_back(8'h08);
        b = 8'($urandom_range(255));
        send_now(b);
        wait_count(2, 1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL gap_write_timeout: got none expected 1 write"); end
        foreach (log_q[i]) if (log_q[i].kind == 0 && log_q[i].cyc < log_q[$].cyc) sc.push_back(log_q[i].cyc);
        nstat = sc.size();
        checks++; if (nstat != 4) begin failures++; $display("FAIL gap_stat_reads: got %0d expected 4", nstat); end
        // AR beat, R beat, then IDLE for the countdown POLL_GAP..0 before the next AR.
        for (int i = 1; i < 4 && i < nstat; i++) begin
            checks++; if (sc[i] - sc[i-1] != POLL_GAP + 3) begin
                failures++; $display("FAIL gap_spacing%0d: got %0d expected %0d", i, sc[i] - sc[i-1], POLL_GAP + 3); end
        end
        checks++; if (log_q[$].data !== {24'h0, b}) begin failures++; $display("FAIL gap_wdata: got %h expected %h", log_q[$].data, b); end
    endtask

    task automatic test_rx_hold();
        bit ok; int n0;
        apply_reset();
        stat_default = 8'h01;
        rx_q.push_back(8'hA3); rx_q.push_back(8'h3C);
        wait_rxv(60, ok);
        checks++; if (!ok || rx_data !== 8'hA3) begin failures++; $display("FAIL rx_first: got valid %b data %h expected 1 a3", rx_valid, rx_data); end
        n0 = log_q.size();
        repeat (40) @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA3) begin failures++; $display("FAIL rx_held: got %b %h expected 1 a3", rx_valid, rx_data); end
        checks++; if (log_q.size() != n0) begin failures++; $display("FAIL rx_no_poll: got %0d new bus ops expected 0", log_q.size() - n0); end
        rx_ready = 1; @(posedge clk); #1; rx_ready = 0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_freed: got %b expected 0", rx_valid); end
        wait_rxv(60, ok);
        checks++; if (!ok || rx_data !== 8'h3C) begin failures++; $display("FAIL rx_second: got valid %b data %h expected 1 3c", rx_valid, rx_data); end
        checks++; if (count_kind(1) != 2) begin failures++; $display("FAIL rx_read_count: got %0d expected 2", count_kind(1)); end
    endtask

    task automatic test_priority();
        logic [7:0] b1, b2, b3, r1, r2; bit ok; int seq[$]; logic [31:0] wd[$];
        apply_reset();
        stat_default = 8'h01;
        b1 = 8'($urandom_range(255)); b2 = 8'($urandom_range(255)); b3 = 8'($urandom_range(255));
        r1 = 8'($urandom_range(255)); r2 = 8'($urandom_range(255));
        rx_q.push_back(r1); rx_q.push_back(r2);
        send_now(b1);
        wait_rxv(100, ok);
        checks++; if (!ok || rx_data !== r1) begin failures++; $display("FAIL prio_r1: got %h expected %h", rx_data, r1); end
        repeat (10) @(posedge clk); #1;
        send_now(b2);
        wait_count(2, 2, 100, ok);
        repeat (5) @(posedge clk); #1;
        checks++; if ({tx_ready, rx_valid} !== 2'b11) begin failures++; $display("FAIL prio_slots_before: got %b expected 11", {tx_ready, rx_valid}); end
        tx_data = b3; tx_valid = 1; rx_ready = 1;
        @(posedge clk); #1;
        tx_valid = 0; rx_ready = 0;
        wait_count(2, 3, 150, ok);
        checks++; if (!ok) begin failures++; $display("FAIL prio_timeout: got %0d writes expected 3", count_kind(2)); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== r2) begin failures++; $display("FAIL prio_r2: got %b %h expected 1 %h", rx_valid, rx_data, r2); end
        foreach (log_q[i]) if (log_q[i].kind != 0) begin seq.push_back(log_q[i].kind); if (log_q[i].kind == 2) wd.push_back(log_q[i].data); end
        checks++; if (seq != '{2, 1, 2, 1, 2}) begin failures++; $display("FAIL prio_order: got %p expected '{2,1,2,1,2}", seq); end
        checks++; if (wd.size() != 3 || wd[0] !== {24'h0, b1} || wd[1] !== {24'h0, b2} || wd[2] !== {24'h0, b3}) begin
            failures++; $display("FAIL prio_wdata: got %p expected %h %h %h", wd, b1, b2, b3); end
    endtask

    task automatic test_split_resp();
        int aw_cyc = 0, w_cyc = 0; bit split = 0; bit ok;
        apply_reset();
        aw_wait = 0; w_wait = 2; bresp_cfg = 2'b10;
        send_now(8'hC7);
        repeat (30) begin
            @(posedge clk); #1;
            aw_cyc += int'(bus.awvalid); w_cyc += int'(bus.wvalid);
            if (!bus.awvalid && bus.wvalid) split = 1;
        end
        checks++; if (aw_cyc != 1) begin failures++; $display("FAIL split_aw_cycles: got %0d expected 1", aw_cyc); end
        checks++; if (w_cyc != 3) begin failures++; $display("FAIL split_w_cycles: got %0d expected 3", w_cyc); end
        checks++; if (!split) begin failures++; $display("FAIL split_independent: got 0 expected 1"); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL split_err_set: got %b expected 1", err); end
        bresp_cfg = 2'b00;
        send_now(8'h11);
        wait_count(2, 2, 100, ok);
        repeat (5) @(posedge clk); #1;
        checks++; if ({ok, err, tx_ready} !== 3'b111) begin failures++; $display("FAIL split_err_sticky: got ok,err,tx_ready=%b expected 111", {ok, err, tx_ready}); end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_tx[$], exp_rx[$], got_rx[$];
        logic [7:0] b, d; bit acc, got, ok; int n, m, nw;
        apply_reset();
        stat_dynamic = 1; tx_full_pct = 25;
        ar_wait = $urandom_range(3); r_wait = $urandom_range(3); aw_wait = $urandom_range(3);
        w_wait = $urandom_range(3); b_wait = $urandom_range(3);
        for (int i = 0; i < 8; i++) begin d = 8'($urandom_range(255)); rx_q.push_back(d); exp_rx.push_back(d); end
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    b = 8'($urandom_range(255));
                    tx_data = b; tx_valid = 1; acc = 0; n = 0;
                    while (!acc && n < 500) begin
                        acc = tx_ready;
                        @(posedge clk); #1; n++;
                    end
                    tx_valid = 0;
                    if (acc) exp_tx.push_back(b);
                    repeat ($urandom_range(4)) @(posedge clk);
                    #0;
                end
            end
            begin
                m = 0;
                while (got_rx.size() < 8 && m < 4000) begin
                    rx_ready = 1'($urandom_range(1));
                    got = rx_valid && rx_ready; d = rx_data;
                    @(posedge clk); #1; m++;
                    if (got) got_rx.push_back(d);
                end
                rx_ready = 0;
            end
        join
        wait_count(2, 12, 1000, ok);
        nw = count_kind(2);
        checks++; if (exp_tx.size() != 12 || nw != 12) begin failures++; $display("FAIL rand_write_count: got %0d writes %0d accepted expected 12", nw, exp_tx.size()); end
        m = 0;
        foreach (log_q[i]) if (log_q[i].kind == 2 && m < exp_tx.size()) begin
            checks++; if (log_q[i].addr !== 4'h4 || log_q[i].data !== {24'h0, exp_tx[m]} || log_q[i].strb !== 4'b0001) begin
                failures++; $display("FAIL rand_write%0d: got %h/%h/%b expected 4/%h/0001", m, log_q[i].addr, log_q[i].data, log_q[i].strb, exp_tx[m]); end
            m++;
        end
        checks++; if (got_rx != exp_rx) begin failures++; $display("FAIL rand_rx_stream: got %p expected %p", got_rx, exp_rx); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rand_err: got %b expected 0", err); end
    endtask

    task automatic test_reset_mid();
        bit ok = 0; int k = 0;
        apply_reset();
        stat_default = 8'h01; r_wait = 5;
        rx_q.push_back(8'h77);
        while (!ok && k < 100) begin
            if (bus.rready && bus.araddr == 4'h0) ok = 1;
            else begin @(posedge clk); #1; k++; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL mid_reach_rx_r: got timeout expected RX read beat"); end
        send_now(8'h99);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL mid_tx_taken: got %b expected 0", tx_ready); end
        #2 rstn = 0;
        #1;
        checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.rvalid, bus.bvalid} !== 7'b0) begin
            failures++; $display("FAIL mid_valids_drop: got %b expected 0000000",
                                 {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.rvalid, bus.bvalid}); end
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;
        checks++; if ({tx_ready, rx_valid, err} !== 3'b100) begin failures++; $display("FAIL mid_after_release: got %b expected 100", {tx_ready, rx_valid, err}); end
        checks++; if (viol != 0) begin failures++; $display("FAIL protocol_monitor: got %0d violations expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_tx_latency();
        test_poll_gap();
        test_rx_hold();
        test_priority();
        test_split_resp();
        test_random_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
